// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle between the two writeback requesters and the regfile write port.
// Handshake: a requester raises *_valid with stable addr/data and holds them until it
// sees *_ready=1 in the same cycle; valid&ready on a clock edge is one accepted write.
interface rf_wport_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            p0_valid;
  logic            p0_ready;
  logic [AW-1:0]   p0_addr;
  logic [XLEN-1:0] p0_data;
  logic            p1_valid;
  logic            p1_ready;
  logic [AW-1:0]   p1_addr;
  logic [XLEN-1:0] p1_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            init_done;
  logic            fsm_run;   // debug view of the FSM: 0 = INIT sweep, 1 = RUN

  modport master (
    output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    input  p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata, init_done, fsm_run
  );

  modport slave (
    input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    output p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata, init_done, fsm_run
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Owner of the regfile write port: zero-fills x1..x(NREGS-1) after reset, then
// arbitrates ALU/WB (P0, priority) against the long-latency unit (P1, anti-starvation).
module rf_wport_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter bit INIT_ZERO  = 1'b1,
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            rst,
    rf_wport_arbiter_if.slave bus
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT_ZERO ? S_INIT : S_RUN;
            idx_q    <= AW'(1);
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        starve_d = starve_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        case (state_q)
            S_INIT: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = '0;
                idx_d   = idx_q + AW'(1);
                if (idx_q == AW'(NREGS - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                done_d = 1'b1;
                // The starvation override only fires once P1 has been refused STARVE_MAX times in a row.
                if (starve_q == SW'(STARVE_MAX) && bus.p1_valid) gnt1 = 1'b1;
                else if (bus.p0_valid)                            gnt0 = 1'b1;
                else if (bus.p1_valid)                            gnt1 = 1'b1;

                if (gnt0) begin
                    we_d    = (bus.p0_addr != '0);
                    waddr_d = bus.p0_addr;
                    wdata_d = bus.p0_data;
                end else if (gnt1) begin
                    we_d    = (bus.p1_addr != '0);
                    waddr_d = bus.p1_addr;
                    wdata_d = bus.p1_data;
                end

                if (bus.p1_valid && !gnt1) begin
                    if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing is acknowledged and then dropped.
    assign bus.p0_ready  = gnt0 & ~rst;
    assign bus.p1_ready  = gnt1 & ~rst;
    assign bus.rf_we     = we_q;
    assign bus.rf_waddr  = waddr_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.init_done = done_q;
    assign bus.fsm_run   = (state_q == S_RUN);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: sweep, single P1 write, starvation pattern,
// x0 filter, same-address collision and reset during the sweep.
module tb_rf_wport_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rf_wport_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    rf_wport_arbiter #(
        .XLEN(32), .NREGS(32), .INIT_ZERO(1'b1), .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p0(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.p0_valid = v;
        bus.p0_addr  = a;
        bus.p0_data  = d;
    endtask

    task automatic drive_p1(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.p1_valid = v;
        bus.p1_addr  = a;
        bus.p1_data  = d;
    endtask

    // Expects a full sweep starting on the next edge, with both requesters asking throughout.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk({tag, "_we"},    32'(bus.rf_we),    32'd1);
            chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(k));
            chk({tag, "_wdata"}, bus.rf_wdata,      32'd0);
            chk({tag, "_done"},  32'(bus.init_done), (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) begin
                chk({tag, "_p0_ready"}, 32'(bus.p0_ready), 32'd0);
                chk({tag, "_p1_ready"}, 32'(bus.p1_ready), 32'd0);
            end
        end
    endtask

    initial begin
        logic exp_p1;

        // Reset state, with both requesters already asking
        rst = 1'b1;
        drive_p0(1'b1, 5'd2, 32'h0000_00AA);
        drive_p1(1'b1, 5'd3, 32'h0000_00BB);
        tick();
        tick();
        chk("rst_we",       32'(bus.rf_we),     32'd0);
        chk("rst_waddr",    32'(bus.rf_waddr),  32'd0);
        chk("rst_wdata",    bus.rf_wdata,       32'd0);
        chk("rst_done",     32'(bus.init_done), 32'd0);
        chk("rst_p0_ready", 32'(bus.p0_ready),  32'd0);
        chk("rst_p1_ready", 32'(bus.p1_ready),  32'd0);

        // T1 sweep
        rst = 1'b0;
        #1;
        chk("t1_ready_first", 32'(bus.p0_ready | bus.p1_ready), 32'd0);
        sweep_check("t1");
        drive_p0(1'b0, 5'd0, 32'd0);
        drive_p1(1'b0, 5'd0, 32'd0);
        tick();
        chk("t1_idle_we",    32'(bus.rf_we),    32'd0);
        chk("t1_idle_waddr", 32'(bus.rf_waddr), 32'd31);

        // T2 single P1 request
        drive_p1(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("t2_p1_ready", 32'(bus.p1_ready), 32'd1);
        chk("t2_p0_ready", 32'(bus.p0_ready), 32'd0);
        tick();
        chk("t2_we",    32'(bus.rf_we),    32'd1);
        chk("t2_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("t2_wdata", bus.rf_wdata,      32'hDEAD_BEEF);
        drive_p1(1'b0, 5'd0, 32'd0);
        tick();
        chk("t2_we_after",    32'(bus.rf_we),    32'd0);
        chk("t2_wdata_hold",  bus.rf_wdata,      32'hDEAD_BEEF);

        // T3 starvation: P0 four times, then P1, repeated
        for (int c = 0; c < 10; c++) begin
            drive_p0(1'b1, 5'd3, 32'h100 + 32'(c));
            drive_p1(1'b1, 5'd4, 32'h200 + 32'(c / 5));
            #1;
            exp_p1 = (c % 5 == 4);
            chk("t3_p0_ready", 32'(bus.p0_ready), 32'(!exp_p1));
            chk("t3_p1_ready", 32'(bus.p1_ready), 32'(exp_p1));
            tick();
            chk("t3_we",    32'(bus.rf_we),    32'd1);
            chk("t3_waddr", 32'(bus.rf_waddr), exp_p1 ? 32'd4 : 32'd3);
            chk("t3_wdata", bus.rf_wdata,      exp_p1 ? 32'h200 + 32'(c / 5) : 32'h100 + 32'(c));
        end

        // P1 dropping valid clears the denial count
        drive_p0(1'b1, 5'd6, 32'h66);
        drive_p1(1'b1, 5'd8, 32'h88);
        tick();
        tick();
        drive_p1(1'b0, 5'd8, 32'h88);
        tick();
        drive_p1(1'b1, 5'd8, 32'h88);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3b_p1_ready", 32'(bus.p1_ready), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t3b_waddr", 32'(bus.rf_waddr), 32'd8);
        drive_p0(1'b0, 5'd0, 32'd0);
        drive_p1(1'b0, 5'd0, 32'd0);
        tick();

        // T4 write to x0 is accepted but never reaches the regfile
        drive_p0(1'b1, 5'd0, 32'h1234);
        #1;
        chk("t4_p0_ready", 32'(bus.p0_ready), 32'd1);
        tick();
        chk("t4_we", 32'(bus.rf_we), 32'd0);
        drive_p0(1'b0, 5'd0, 32'd0);
        tick();

        // T5 same-cycle same-address collision
        drive_p0(1'b1, 5'd7, 32'hAAAA_0007);
        drive_p1(1'b1, 5'd7, 32'hBBBB_0007);
        #1;
        chk("t5_p0_ready", 32'(bus.p0_ready), 32'd1);
        chk("t5_p1_ready", 32'(bus.p1_ready), 32'd0);
        tick();
        chk("t5_a_we",    32'(bus.rf_we),    32'd1);
        chk("t5_a_waddr", 32'(bus.rf_waddr), 32'd7);
        chk("t5_a_wdata", bus.rf_wdata,      32'hAAAA_0007);
        drive_p0(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_p1_ready2", 32'(bus.p1_ready), 32'd1);
        tick();
        chk("t5_b_we",    32'(bus.rf_we),    32'd1);
        chk("t5_b_waddr", 32'(bus.rf_waddr), 32'd7);
        chk("t5_b_wdata", bus.rf_wdata,      32'hBBBB_0007);
        drive_p1(1'b0, 5'd0, 32'd0);
        tick();

        // T6 reset in the middle of a sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_p0(1'b1, 5'd9, 32'h99);
        drive_p1(1'b1, 5'd10, 32'hA0);
        for (int k = 1; k <= 9; k++) tick();
        chk("t6_pre_waddr", 32'(bus.rf_waddr), 32'd9);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(bus.p0_ready | bus.p1_ready), 32'd0);
        tick();
        chk("t6_rst_we",   32'(bus.rf_we),     32'd0);
        chk("t6_rst_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        sweep_check("t6");
        drive_p0(1'b0, 5'd0, 32'd0);
        drive_p1(1'b0, 5'd0, 32'd0);
        tick();
        chk("t6_end_we", 32'(bus.rf_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
